// File: rtl/t5_pkg.sv
// ---------------------------------------------------------------------------
// t5_pkg
// Shared types and constants for the T5 barrel-threaded core front end.
//   T5_NHART    : number of hardware threads (harts)
//   hart_t      : hart index
//   wadr_t      : 32-bit byte address with bits [1:0] dropped (word address)
//   T5_RSTV_DEF : default reset vector
//   fetch_st_e  : fetch FSM state encoding
//   t5_first_hart() : lowest enabled hart in a mask (0 for an empty mask)
// ---------------------------------------------------------------------------
package t5_pkg;

  localparam int T5_NHART = 4;

  typedef logic [1:0]  hart_t;
  typedef logic [29:0] wadr_t;

  localparam logic [31:0] T5_RSTV_DEF = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fetch_st_e;

  // Scans from the top down so the lowest set bit is the last one written.
  function automatic hart_t t5_first_hart(input logic [T5_NHART-1:0] mask);
    hart_t r;
    r = '0;
    for (int i = T5_NHART - 1; i >= 0; i--) begin
      if (mask[i]) r = hart_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/t5_fetch_if.sv
// ---------------------------------------------------------------------------
// t5_fetch_if
// Wishbone classic read-only instruction bus.
//   iwb_adr : word address [31:2]
//   iwb_cyc : cycle
//   iwb_stb : strobe
//   iwb_we  : write enable (always 0 from the fetch unit)
//   iwb_sel : byte selects
//   iwb_ack : acknowledge from the memory side
// Modports: master (fetch unit), slave (memory).
// ---------------------------------------------------------------------------
interface t5_fetch_if;
  import t5_pkg::*;

  wadr_t       iwb_adr;
  logic        iwb_cyc;
  logic        iwb_stb;
  logic        iwb_we;
  logic [3:0]  iwb_sel;
  logic        iwb_ack;

  modport master (
    output iwb_adr,
    output iwb_cyc,
    output iwb_stb,
    output iwb_we,
    output iwb_sel,
    input  iwb_ack
  );

  modport slave (
    input  iwb_adr,
    input  iwb_cyc,
    input  iwb_stb,
    input  iwb_we,
    input  iwb_sel,
    output iwb_ack
  );

endinterface

// File: rtl/t5_fetch_rr.sv
// ---------------------------------------------------------------------------
// t5_fetch_rr
// Combinational round-robin picker: returns the next enabled hart strictly
// above the current one (cyclically). If no other hart is enabled the
// current hart is returned, which lets a single-hart mask fetch back to back.
//   cur   : hart currently owning the fetch
//   hmask : hart enable mask
//   nxt   : next hart to fetch
// ---------------------------------------------------------------------------
module t5_fetch_rr
  import t5_pkg::*;
(
  input  hart_t                cur,
  input  logic [T5_NHART-1:0]  hmask,
  output hart_t                nxt
);

  hart_t cand;

  // Walk offsets from farthest to nearest so the nearest enabled hart wins.
  always_comb begin
    nxt  = cur;
    cand = cur;
    for (int i = T5_NHART - 1; i >= 1; i--) begin
      cand = cur + hart_t'(i);
      if (hmask[cand]) nxt = cand;
    end
  end

endmodule

// File: rtl/t5_fetch.sv
// ---------------------------------------------------------------------------
// t5_fetch
// Instruction-fetch stage of the barrel-threaded core. Keeps one PC per hart,
// picks harts round-robin among those enabled in HMASK and issues Wishbone
// classic reads. When an instruction returns it presents fpc/fhart/fval and
// raises sena so the decode stage latches iwb_dat in the same cycle.
//
// Parameters
//   RSTV  : reset vector loaded into every hart PC (bits [1:0] ignored)
//   HMASK : hart enable mask (must be non-zero for fetching to start)
// Ports
//   sclk  : core clock
//   srst  : asynchronous active-low reset
//   iwb   : instruction bus, master side
//   fpc   : word address of the instruction on iwb_dat
//   fhart : hart owning the current fetch
//   fval  : returned instruction is valid (not killed by a redirect)
//   sena  : pipeline advance, iwb_cyc & iwb_ack
//   xred  : redirect request from execute
//   xhart : hart being redirected
//   xtgt  : redirect target word address
// ---------------------------------------------------------------------------
module t5_fetch
  import t5_pkg::*;
#(
  parameter logic [31:0]         RSTV  = T5_RSTV_DEF,
  parameter logic [T5_NHART-1:0] HMASK = 4'b0001
)
(
  input  logic          sclk,
  input  logic          srst,
  t5_fetch_if.master    iwb,
  output wadr_t         fpc,
  output hart_t         fhart,
  output logic          fval,
  output logic          sena,
  input  logic          xred,
  input  hart_t         xhart,
  input  wadr_t         xtgt
);

  localparam wadr_t RST_PC  = RSTV[31:2];
  localparam hart_t RST_PTR = t5_first_hart(HMASK);

  fetch_st_e state_q, state_d;
  hart_t     ptr_q,   ptr_d;
  hart_t     hart_q,  hart_d;
  wadr_t     adr_q,   adr_d;
  logic      kill_q,  kill_d;
  wadr_t     pc_q [T5_NHART];
  wadr_t     pc_d [T5_NHART];

  logic      busy;
  logic      ack_hit;
  logic      red_cur;
  logic      killed;
  hart_t     rr_nxt;

  t5_fetch_rr u_rr (
    .cur   (hart_q),
    .hmask (HMASK),
    .nxt   (rr_nxt)
  );

  assign busy    = (state_q == ST_BUSY);
  assign ack_hit = busy & iwb.iwb_ack;
  // A redirect aimed at the in-flight hart kills that fetch, including when
  // it lands on the very edge the ack arrives.
  assign red_cur = busy & xred & (xhart == hart_q);
  assign killed  = kill_q | red_cur;

  // PC file next state. The redirect is applied after the increment so it
  // wins whenever both target the same hart.
  always_comb begin
    for (int h = 0; h < T5_NHART; h++) begin
      pc_d[h] = pc_q[h];
    end
    if (ack_hit && !killed) begin
      pc_d[hart_q] = adr_q + wadr_t'(1);
    end
    if (xred) begin
      pc_d[xhart] = xtgt;
    end
  end

  // Fetch FSM. New requests read pc_d so a PC written on this edge (by an
  // increment or a redirect) is fetched immediately without a bubble.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hart_d  = hart_q;
    adr_d   = adr_q;
    kill_d  = kill_q;
    unique case (state_q)
      ST_IDLE: begin
        if (HMASK != '0) begin
          state_d = ST_BUSY;
          adr_d   = pc_d[ptr_q];
          hart_d  = ptr_q;
          kill_d  = 1'b0;
        end
      end
      ST_BUSY: begin
        if (iwb.iwb_ack) begin
          ptr_d  = rr_nxt;
          hart_d = rr_nxt;
          adr_d  = pc_d[rr_nxt];
          kill_d = 1'b0;
        end else if (red_cur) begin
          kill_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      state_q <= ST_IDLE;
      ptr_q   <= RST_PTR;
      hart_q  <= RST_PTR;
      adr_q   <= RST_PC;
      kill_q  <= 1'b0;
      for (int h = 0; h < T5_NHART; h++) begin
        pc_q[h] <= RST_PC;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hart_q  <= hart_d;
      adr_q   <= adr_d;
      kill_q  <= kill_d;
      for (int h = 0; h < T5_NHART; h++) begin
        pc_q[h] <= pc_d[h];
      end
    end
  end

  assign iwb.iwb_adr = adr_q;
  assign iwb.iwb_cyc = busy;
  assign iwb.iwb_stb = busy;
  assign iwb.iwb_we  = 1'b0;
  assign iwb.iwb_sel = 4'hF;

  assign fpc   = adr_q;
  assign fhart = hart_q;
  assign sena  = ack_hit;
  assign fval  = ack_hit & ~killed;

endmodule
